axi_master_wr: RTL and testbench
================================

Name: axi_master_wr

Overview:
- AXI4 write master sitting directly downstream of the multichannel write arbiter.
- Accepts one arbitrated burst request (start, address, length) and issues it on the AW channel.
- Streams the burst's data beats on the W channel, popping the granted channel's data with a per-beat ready pulse.
- Waits for the B response, then returns a one-cycle done pulse that the arbiter uses to rotate grant.

Parameters:
- AXI_WIDTH, 64, W-channel data width in bits (8..1024, power of two).
- AXI_AXSIZE, 3'b011, AWSIZE value; must equal log2(AXI_WIDTH/8).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_start  input  1  level burst request from arbiter
- wr_addr  input  30  burst start byte address
- wr_len  input  8  burst length minus one (AXI AWLEN encoding)
- wr_data  input  AXI_WIDTH  current beat data; show-ahead, held until wr_ready
- wr_ready  output  1  one-cycle pulse per accepted W beat; upstream pops next word
- wr_done  output  1  one-cycle pulse when the burst's B response is accepted
- wr_err  output  1  one-cycle pulse coincident with wr_done when BRESP != 2'b00
- m_axi_awid  output  4  tied 0
- m_axi_awaddr  output  30  burst address
- m_axi_awlen  output  8  burst length minus one
- m_axi_awsize  output  3  AXI_AXSIZE
- m_axi_awburst  output  2  2'b01 (INCR)
- m_axi_awvalid  output  1  address valid
- m_axi_awready  input  1  address ready
- m_axi_wdata  output  AXI_WIDTH  write data
- m_axi_wstrb  output  AXI_WIDTH/8  all ones
- m_axi_wlast  output  1  last beat
- m_axi_wvalid  output  1  data valid
- m_axi_wready  input  1  data ready
- m_axi_bid  input  4  ignored
- m_axi_bresp  input  2  write response
- m_axi_bvalid  input  1  response valid
- m_axi_bready  output  1  response ready

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - State returns to IDLE; beat counter and latched address/length clear to 0.
  - awvalid, wvalid, wlast, bready, wr_ready, wr_done and wr_err go to 0.
  - No attempt is made to complete an in-flight AXI transaction.
- Static outputs: awid=0, awsize=AXI_AXSIZE, awburst=2'b01, and wstrb all ones at all times.
- State machine, one-hot, states IDLE, WA, WD, WB, DONE:
  - IDLE: if wr_start=1, latch wr_addr and wr_len, clear the beat counter, and go to WA next cycle. Otherwise stay in IDLE.
  - WA:
    - awvalid=1, with awaddr/awlen driven from the latched registers.
    - Payload is stable while awvalid=1 and awready=0.
    - On awvalid & awready, go to WD.
  - WD:
    - wvalid=1 and wdata=wr_data (combinational pass-through).
    - wlast=1 when beat counter == latched len.
    - wr_ready = wvalid & wready, same cycle.
    - On each handshake the counter increments (8-bit; len=255 gives 256 beats, so the counter never wraps within a burst).
    - On the handshake with wlast=1, go to WB.
    - While wready=0, wdata must stay stable; upstream guarantees this by holding wr_data until wr_ready.
  - WB: bready=1. On bvalid, capture (bresp != 0) and go to DONE.
  - DONE:
    - wr_done=1 for exactly one cycle; wr_err=1 in the same cycle if the captured bresp was nonzero.
    - Then go to IDLE unconditionally.
    - wr_start is not sampled in DONE, so the arbiter and controller have one cycle to drop or re-steer the level request.
- wr_start is ignored in every state except IDLE; it has no effect while a burst is in flight.
- Changes to wr_addr/wr_len after latching in IDLE have no effect on the current burst.
- AW strictly precedes W; W beats are never issued before the AW handshake.
- Latency:
  - IDLE with wr_start=1 gives awvalid on the next cycle.
  - If awready, wready and bvalid are all held high, a burst of N beats takes N+4 cycles from start sample to wr_done.
- awready arriving in the same cycle awvalid first rises is a valid handshake.
- bvalid arriving early (before WB) is not accepted; bready is 0 outside WB.

Test Plan:
- Single beat: wr_start=1, addr=30'h100, len=0, all ready high.
  - Expect AW handshake with awaddr=30'h100, awlen=0; one W beat with wlast=1 and one wr_ready pulse; bready high one cycle; wr_done exactly 5 cycles after the start sample.
- 16-beat burst, len=15, wr_data incrementing 0..15 on each wr_ready; wready toggling 1,0,1,0.
  - Expect exactly 16 wr_ready pulses, wdata sequence 0..15, wlast only on beat 15, and wdata stable during every wready=0 cycle.
- Backpressure: awready held low 5 cycles, bvalid delayed 7 cycles, bresp=2'b10.
  - Expect awvalid held with constant awaddr/awlen; a single wr_done and wr_err pulse in the same cycle.
- Maximum length: len=255.
  - Expect 256 beats, wlast on beat 256 only, and the counter does not wrap early.
- Level request and interference:
  - Hold wr_start=1 continuously and change wr_addr mid-burst: the current burst uses the originally latched address; no wr_start sampling in DONE; the next burst's awvalid rises 2 cycles after wr_done.
  - Drive bvalid=1 during WA: it is ignored (bready=0).
- Reset mid-WD (after beat 3 of 8): rst_n=0.
  - Expect immediate awvalid, wvalid, bready, wr_ready and wr_done all 0 and state IDLE; after reset release, a new request behaves as in the single-beat case.

Source files
------------

// File: rtl/axi_master_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write master and the interconnect.
interface axi_master_wr_if #(
  parameter int AXI_WIDTH = 64
);
  logic [3:0]             awid;
  logic [29:0]            awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [AXI_WIDTH-1:0]   wdata;
  logic [AXI_WIDTH/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [3:0]             bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_master_wr.sv
// AXI4 write master: issues one arbitrated INCR burst (AW, W beats, B) and
// pulses wr_done (and wr_err on a non-OKAY response) when the response lands.
module axi_master_wr #(
  parameter int         AXI_WIDTH  = 64,
  parameter logic [2:0] AXI_AXSIZE = 3'b011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_start,
  input  logic [29:0]          wr_addr,
  input  logic [7:0]           wr_len,
  input  logic [AXI_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 wr_done,
  output logic                 wr_err,
  axi_master_wr_if.master      m_axi
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    WA   = 5'b00010,
    WD   = 5'b00100,
    WB   = 5'b01000,
    DONE = 5'b10000
  } state_e;

  state_e      state_q;
  logic [29:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        done_q;
  logic        err_q;
  logic        unused_bid;

  assign cnt_d      = cnt_q + 8'd1;
  assign unused_bid = ^m_axi.bid;

  assign m_axi.awid    = 4'd0;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AXI_AXSIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid_q;
  // Upstream holds wr_data until it sees wr_ready, so wdata is stable under backpressure.
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wvalid_q && (cnt_q == len_q);
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign wr_ready = wvalid_q & m_axi.wready;
  assign wr_done  = done_q;
  assign wr_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_start) begin
            addr_q    <= wr_addr;
            len_q     <= wr_len;
            cnt_q     <= '0;
            awvalid_q <= 1'b1;
            state_q   <= WA;
          end
        end
        WA: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= WD;
          end
        end
        WD: begin
          // 8-bit counter: the wrap after beat 256 only happens once the burst has left WD.
          if (m_axi.wready) begin
            cnt_q <= cnt_d;
            if (cnt_q == len_q) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= WB;
            end
          end
        end
        WB: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= (m_axi.bresp != 2'b00);
            state_q  <= DONE;
          end
        end
        DONE: begin
          // wr_start deliberately not sampled here so the arbiter can re-steer its level request.
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_wr.sv
// Bench for axi_master_wr: transaction-level model checked every cycle plus directed literal checks.
module tb_axi_master_wr;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_start = 1'b0;
  logic [29:0]  wr_addr = '0;
  logic [7:0]   wr_len = '0;
  logic [W-1:0] wr_data;
  logic         wr_ready, wr_done, wr_err;

  always #5 clk = ~clk;

  axi_master_wr_if #(.AXI_WIDTH(W)) bus ();

  axi_master_wr #(.AXI_WIDTH(W), .AXI_AXSIZE(3'b011)) dut (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err), .m_axi(bus)
  );

  // stimulus configuration (written by the sequence)
  int          cfg_aw_delay = 0;
  int          cfg_b_delay  = 0;
  bit          cfg_wtog     = 1'b0;
  bit          cfg_bforce   = 1'b0;
  logic [1:0]  cfg_bresp    = 2'b00;
  logic [63:0] up_base      = '0;

  // observations (written by the compare process)
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          rdy_cnt = 0, wlast_cnt = 0, wlast_beat = 0, done_cnt = 0, err_cnt = 0;
  int          awv_cyc = 0, brdy_cyc = 0, done_cyc = 0, awrise_cyc = 0;
  logic [29:0] hs_addr = '0;
  logic [7:0]  hs_len = '0;
  bit          awv_seen = 0, brdy_seen = 0, rdy_seen = 0, prev_wstall = 0, prev_awv = 0;
  logic [63:0] prev_wdata = '0;

  // literal-check handoff from the sequence to the compare process
  int          lit_seq = 0, lit_ack = 0;
  string       lit_name;
  logic [63:0] lit_act, lit_exp;

  // transaction model
  bit          m_free = 1, m_aw = 0, m_w = 0, m_b = 0, m_done = 0, m_err = 0;
  int          m_beat = 0, m_len = 0;
  logic [29:0] m_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave / upstream responder
  initial begin
    int aw_cnt, b_cnt, up_idx;
    aw_cnt = 0; b_cnt = 0; up_idx = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = 4'hA;
    wr_data = '0;
    forever begin
      @(posedge clk); #1;
      aw_cnt = awv_seen ? aw_cnt + 1 : 0;
      b_cnt  = brdy_seen ? b_cnt + 1 : 0;
      if (awv_seen) up_idx = 0;
      else if (rdy_seen) up_idx++;
      bus.awready = (aw_cnt >= cfg_aw_delay);
      bus.wready  = cfg_wtog ? ~bus.wready : 1'b1;
      bus.bvalid  = cfg_bforce || (b_cnt >= cfg_b_delay);
      bus.bresp   = cfg_bresp;
      wr_data     = up_base + 64'(up_idx);
    end
  end

  // Compare process
  initial begin
    bit nf, n_aw, n_w, n_b, n_done;
    int n_beat;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_free = 1; m_aw = 0; m_w = 0; m_b = 0; m_done = 0; m_err = 0; m_beat = 0;
      end
      chk("awvalid", 64'(bus.awvalid), 64'(m_aw));
      chk("wvalid", 64'(bus.wvalid), 64'(m_w));
      chk("wlast", 64'(bus.wlast), 64'(m_w && (m_beat == m_len)));
      chk("wr_ready", 64'(wr_ready), 64'(m_w && bus.wready));
      chk("bready", 64'(bus.bready), 64'(m_b));
      chk("wr_done", 64'(wr_done), 64'(m_done));
      chk("wr_err", 64'(wr_err), 64'(m_done && m_err));
      chk("awid", 64'(bus.awid), 64'd0);
      chk("awsize", 64'(bus.awsize), 64'd3);
      chk("awburst", 64'(bus.awburst), 64'd1);
      chk("wstrb", 64'(bus.wstrb), 64'hFF);
      if (m_aw) begin
        chk("awaddr", 64'(bus.awaddr), 64'(m_addr));
        chk("awlen", 64'(bus.awlen), 64'(m_len));
      end
      if (m_w) chk("wdata", bus.wdata, up_base + 64'(m_beat));
      if (prev_wstall && bus.wvalid) chk("wdata_hold", bus.wdata, prev_wdata);
      if (lit_seq != lit_ack) begin
        chk(lit_name, lit_act, lit_exp);
        lit_ack = lit_seq;
      end

      if (wr_ready) rdy_cnt++;
      if (wr_ready && bus.wlast) begin wlast_cnt++; wlast_beat = rdy_cnt; end
      if (wr_done) begin done_cnt++; done_cyc = cyc; end
      if (wr_err) err_cnt++;
      if (bus.awvalid) awv_cyc++;
      if (bus.awvalid && !prev_awv) awrise_cyc = cyc;
      if (bus.awvalid && bus.awready) begin hs_addr = bus.awaddr; hs_len = bus.awlen; end
      if (bus.bready) brdy_cyc++;
      awv_seen = bus.awvalid; brdy_seen = bus.bready; rdy_seen = wr_ready;
      prev_wstall = bus.wvalid && !bus.wready; prev_wdata = bus.wdata; prev_awv = bus.awvalid;

      if (rst_n) begin
        nf = (m_free && !wr_start) || m_done;
        n_aw = m_aw; n_w = m_w; n_b = m_b; n_done = 0; n_beat = m_beat;
        if (m_free && wr_start) begin n_aw = 1; m_addr = wr_addr; m_len = int'(wr_len); end
        if (m_aw && bus.awready) begin n_aw = 0; n_w = 1; n_beat = 0; end
        if (m_w && bus.wready) begin
          n_beat = m_beat + 1;
          if (m_beat == m_len) begin n_w = 0; n_b = 1; end
        end
        if (m_b && bus.bvalid) begin n_b = 0; n_done = 1; m_err = (bus.bresp != 2'b00); end
        m_free = nf; m_aw = n_aw; m_w = n_w; m_b = n_b; m_done = n_done; m_beat = n_beat;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
    lit_name = nm; lit_act = act; lit_exp = exp;
    lit_seq++;
    @(negedge clk); #1;
  endtask

  task automatic start_burst(input logic [29:0] a, input logic [7:0] l, output int sc);
    wr_addr = a; wr_len = l; wr_start = 1'b1;
    sc = cyc + 1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      idle(1);
      if (done_cnt > d0) got = 1;
    end
    if (!got) post("done_timeout", 64'd0, 64'd1);
  endtask

  // Single beat at 'a', all ready: latency (inclusive) must be N+4 = 5.
  task automatic single_beat(input logic [29:0] a, input string tag);
    int sc, d0, r0, w0, b0;
    d0 = done_cnt; r0 = rdy_cnt; w0 = wlast_cnt; b0 = brdy_cyc;
    start_burst(a, 8'd0, sc);
    idle(1); wr_start = 1'b0;
    wait_done(d0, 50);
    post({tag, "_latency"}, 64'(done_cyc - sc + 1), 64'd5);
    post({tag, "_awaddr"}, 64'(hs_addr), 64'(a));
    post({tag, "_awlen"}, 64'(hs_len), 64'd0);
    post({tag, "_rdy"}, 64'(rdy_cnt - r0), 64'd1);
    post({tag, "_wlast"}, 64'(wlast_cnt - w0), 64'd1);
    post({tag, "_bready"}, 64'(brdy_cyc - b0), 64'd1);
    post({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    idle(2);
  endtask

  initial begin
    int sc, d0, r0, w0, a0, e0;
    bit got;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single beat
    up_base = 64'h1000;
    single_beat(30'h100, "t1");

    // 16 beats, wready toggling, data 0..15
    up_base = 64'd0; cfg_wtog = 1'b1;
    r0 = rdy_cnt; w0 = wlast_cnt; d0 = done_cnt;
    start_burst(30'h2000, 8'd15, sc);
    idle(1); wr_start = 1'b0;
    wait_done(d0, 200);
    post("t2_rdy", 64'(rdy_cnt - r0), 64'd16);
    post("t2_wlast", 64'(wlast_cnt - w0), 64'd1);
    post("t2_lastbeat", 64'(wlast_beat - r0), 64'd16);
    cfg_wtog = 1'b0;
    idle(2);

    // AW and B backpressure with SLVERR; wr_addr disturbed during WA
    cfg_aw_delay = 5; cfg_b_delay = 7; cfg_bresp = 2'b10; up_base = 64'hA5A5_0000;
    a0 = awv_cyc; d0 = done_cnt; e0 = err_cnt;
    start_burst(30'h2ABC_DE00, 8'd0, sc);
    idle(1); wr_start = 1'b0; wr_addr = 30'h0; wr_len = 8'd7;
    wait_done(d0, 100);
    post("t3_awv_cycles", 64'(awv_cyc - a0), 64'd6);
    post("t3_done", 64'(done_cnt - d0), 64'd1);
    post("t3_err", 64'(err_cnt - e0), 64'd1);
    post("t3_latency", 64'(done_cyc - sc + 1), 64'd17);
    cfg_aw_delay = 0; cfg_b_delay = 0; cfg_bresp = 2'b00;
    idle(2);

    // Maximum length: 256 beats
    up_base = 64'hFFFF_FFFF_FFFF_FF00;
    r0 = rdy_cnt; w0 = wlast_cnt; d0 = done_cnt;
    start_burst(30'h1_0000, 8'd255, sc);
    idle(1); wr_start = 1'b0;
    wait_done(d0, 400);
    post("t4_rdy", 64'(rdy_cnt - r0), 64'd256);
    post("t4_wlast", 64'(wlast_cnt - w0), 64'd1);
    post("t4_lastbeat", 64'(wlast_beat - r0), 64'd256);
    post("t4_latency", 64'(done_cyc - sc + 1), 64'd260);
    idle(2);

    // Level request held, address/length changed after latching
    cfg_aw_delay = 2; up_base = 64'h77;
    d0 = done_cnt;
    start_burst(30'h0ABC_0000, 8'd3, sc);
    idle(1); wr_addr = 30'h1234_5678; wr_len = 8'd9;
    wait_done(d0, 100);
    post("t5_first_addr", 64'(hs_addr), 64'h0ABC_0000);
    post("t5_first_len", 64'(hs_len), 64'd3);
    post("t5_first_latency", 64'(done_cyc - sc + 1), 64'd10);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (awrise_cyc > done_cyc) got = 1;
      else idle(1);
    end
    post("t5_rearm_gap", 64'(awrise_cyc - done_cyc), 64'd2);
    wr_start = 1'b0;
    d0 = done_cnt;
    wait_done(d0, 100);
    post("t5_second_addr", 64'(hs_addr), 64'h1234_5678);
    post("t5_second_len", 64'(hs_len), 64'd9);
    cfg_aw_delay = 0;
    idle(2);

    // bvalid high from the start, including during WA
    cfg_bforce = 1'b1; cfg_aw_delay = 3; up_base = 64'h55;
    d0 = done_cnt;
    start_burst(30'h40, 8'd0, sc);
    idle(1); wr_start = 1'b0;
    wait_done(d0, 50);
    post("t6_latency", 64'(done_cyc - sc + 1), 64'd8);
    post("t6_done", 64'(done_cnt - d0), 64'd1);
    cfg_bforce = 1'b0; cfg_aw_delay = 0;
    idle(2);

    // Reset after beat 3 of 8
    up_base = 64'h300;
    r0 = rdy_cnt; d0 = done_cnt;
    start_burst(30'h500, 8'd7, sc);
    idle(1); wr_start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rdy_cnt - r0 >= 3) got = 1;
      else idle(1);
    end
    rst_n = 1'b0;
    post("t7_beats_before_reset", 64'(rdy_cnt - r0), 64'd3);
    idle(2);
    post("t7_no_done", 64'(done_cnt - d0), 64'd0);
    rst_n = 1'b1;
    idle(2);
    up_base = 64'h900;
    single_beat(30'h3F0, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
